pipe_stall_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipelined CPU. It merges three sources into one consistent set of per-stage write-enable, bubble and flush controls: the load-use request from the hazard unit, the branch-taken flush from ID, and a multi-cycle data-memory handshake for the MEM stage. It also keeps saturating stall/flush performance counters and a sticky memory-timeout error flag.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/sat_counter.sv | 31 +++
 rtl/pipe_stall_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and default sizes for the pipeline stall/flush
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Sequencer states: free-running, waiting on data memory, one release cycle
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } state_t;

    localparam int unsigned c_default_timeout_w   = 8;
    localparam int unsigned c_default_stall_cnt_w = 32;
    localparam int unsigned c_default_flush_cnt_w = 16;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
//               clr_i is a synchronous clear and wins over inc_i.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;

    // Count qualifying cycles, holding once the maximum value is reached
    always_ff @(posedge clk) begin
        if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Central stall/flush sequencer. Merges load-use stalls, branch
//               flushes and the data-memory handshake into per-stage enables,
//               and keeps stall/flush performance counters plus a sticky
//               memory-timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_W   = c_default_timeout_w,
    parameter int unsigned STALL_CNT_W = c_default_stall_cnt_w,
    parameter int unsigned FLUSH_CNT_W = c_default_flush_cnt_w
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   LoadUse_i,
    input  logic                   Flush_i,
    input  logic                   EXMEM_MemRead_i,
    input  logic                   EXMEM_MemWrite_i,
    input  logic                   MemAck_i,
    output logic                   MemReq_o,
    output logic                   PCWrite_o,
    output logic                   IFID_Write_o,
    output logic                   IFID_Flush_o,
    output logic                   IDEX_Write_o,
    output logic                   IDEX_NoOp_o,
    output logic                   EXMEM_Write_o,
    output logic                   MEMWB_Write_o,
    output logic                   MemErr_o,
    output logic [STALL_CNT_W-1:0] StallCycles_o,
    output logic [FLUSH_CNT_W-1:0] FlushCount_o
);

    localparam logic [TIMEOUT_W-1:0] c_wait_max = {TIMEOUT_W{1'b1}};

    state_t               r_state;
    state_t               w_state_next;
    logic [TIMEOUT_W-1:0] r_wait_cnt;
    logic [TIMEOUT_W-1:0] w_wait_inc;
    logic                 r_mem_err;
    logic                 w_access;
    logic                 w_timeout;
    logic                 w_freeze;

    assign w_access   = EXMEM_MemRead_i | EXMEM_MemWrite_i;
    assign w_wait_inc = r_wait_cnt + TIMEOUT_W'(1);
    // The timeout cycle is the one in which the count of wait cycles reaches
    // all-ones, so the request is held for exactly 2^TIMEOUT_W-1 cycles.
    assign w_timeout  = (r_state == MEM_WAIT) && (w_wait_inc == c_wait_max);
    // In MEM_DONE the access belongs to the departing instruction, so only
    // RUN may start a new freeze.
    assign w_freeze   = ((r_state == RUN) && w_access) || (r_state == MEM_WAIT);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic for the memory handshake
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:      if (w_access) w_state_next = MEM_WAIT;
            MEM_WAIT: if (MemAck_i || w_timeout) w_state_next = MEM_DONE;
            MEM_DONE: w_state_next = RUN;
            default:  w_state_next = RUN;
        endcase
    end

    // Wait counter: zeroed when the request is launched, counts wait cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait_cnt <= '0;
        end else if ((r_state == RUN) && w_access) begin
            r_wait_cnt <= '0;
        end else if (r_state == MEM_WAIT) begin
            r_wait_cnt <= w_wait_inc;
        end
    end

    // Sticky timeout flag; an ack in the timeout cycle is a normal completion
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem_err <= 1'b0;
        end else if (w_timeout && !MemAck_i) begin
            r_mem_err <= 1'b1;
        end
    end

    assign MemErr_o = r_mem_err;

    // Per-stage control decode: reset, then freeze, then load-use over flush
    always_comb begin
        PCWrite_o     = 1'b0;
        IFID_Write_o  = 1'b0;
        IFID_Flush_o  = 1'b0;
        IDEX_Write_o  = 1'b0;
        IDEX_NoOp_o   = 1'b0;
        EXMEM_Write_o = 1'b0;
        MEMWB_Write_o = 1'b0;
        MemReq_o      = 1'b0;
        if (rst_i) begin
            IDEX_NoOp_o = 1'b1;
        end else if (w_freeze) begin
            MemReq_o = (r_state == MEM_WAIT);
        end else begin
            PCWrite_o     = 1'b1;
            IFID_Write_o  = 1'b1;
            IDEX_Write_o  = 1'b1;
            EXMEM_Write_o = 1'b1;
            MEMWB_Write_o = 1'b1;
            if (LoadUse_i) begin
                // Branch operands are not ready yet, so the flush waits
                PCWrite_o    = 1'b0;
                IFID_Write_o = 1'b0;
                IDEX_NoOp_o  = 1'b1;
            end else if (Flush_i) begin
                IFID_Flush_o = 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk_i),
        .inc_i (!PCWrite_o),
        .clr_i (rst_i),
        .cnt_o (StallCycles_o)
    );

    sat_counter #(
        .WIDTH (FLUSH_CNT_W)
    ) u_flush_cnt (
        .clk   (clk_i),
        .inc_i (IFID_Flush_o),
        .clr_i (rst_i),
        .cnt_o (FlushCount_o)
    );

endmodule : pipe_stall_ctrl
`default_nettype wire
